// File: rtl/mure_pkg.sv
// Shared types for the multi-retirement trace regrouper: widths, FSM state and the group record.
package mure_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned INST_LEN = 32;
  localparam int unsigned SLOTS    = 2;

  typedef enum logic {FILL, CLOSED} regroup_state_e;

  typedef struct packed {
    logic [SLOTS-1:0]          valids;
    logic [SLOTS*INST_LEN-1:0] uops;
    logic [SLOTS*XLEN-1:0]     pcs;
    logic                      exception;
    logic                      interrupt;
    logic [XLEN-1:0]           epc;
  } regroup_t;
endpackage

// File: rtl/mure_regroup_acc.sv
// Accumulator stage: packs retiring beats into slots and closes the group on full, trap or timeout.
module mure_regroup_acc import mure_pkg::*; #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid,
  input  logic                iretired,
  input  logic                exception,
  input  logic                interrupt,
  input  logic [INST_LEN-1:0] inst_data,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     epc,
  input  logic                take,
  output logic                ready,
  output logic                avail,
  output regroup_t            group
);
  localparam int unsigned FW = $clog2(SLOTS + 1);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  regroup_state_e state;
  regroup_t       acc, acc_nxt;
  logic [FW-1:0]  fill, fill_nxt;
  logic [CW-1:0]  tmo, tmo_nxt;
  logic           close;

  always_comb begin
    acc_nxt  = acc;
    fill_nxt = fill;
    tmo_nxt  = tmo;
    close    = 1'b0;
    if (state == FILL) begin
      if (inst_valid) begin
        tmo_nxt = '0;
        if (iretired) begin
          for (int unsigned i = 0; i < SLOTS; i++) begin
            if (fill == FW'(i)) begin
              acc_nxt.valids[i]                   = 1'b1;
              acc_nxt.uops[i*INST_LEN +: INST_LEN] = inst_data;
              acc_nxt.pcs[i*XLEN +: XLEN]         = pc;
            end
          end
          fill_nxt = fill + FW'(1);
        end
        if (exception) begin
          acc_nxt.exception = 1'b1;
          acc_nxt.interrupt = interrupt;
          acc_nxt.epc       = epc;
          close             = 1'b1;
        end
        if (fill_nxt == FW'(SLOTS)) close = 1'b1;
      end else if (fill != '0) begin
        tmo_nxt = tmo + CW'(1);
      end
      // A beat arriving on the timeout cycle still lands in the group being flushed.
      if (fill != '0 && tmo == CW'(TIMEOUT)) close = 1'b1;
    end
  end

  // A group closing this cycle is offered straight to the output stage, avoiding a CLOSED bubble.
  assign avail = (state == CLOSED) || close;
  assign group = (state == CLOSED) ? acc : acc_nxt;
  assign ready = (state == FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      acc   <= '0;
      fill  <= '0;
      tmo   <= '0;
    end else if (avail && take) begin
      state <= FILL;
      acc   <= '0;
      fill  <= '0;
      tmo   <= '0;
    end else if (close) begin
      state <= CLOSED;
      acc   <= acc_nxt;
      fill  <= fill_nxt;
      tmo   <= '0;
    end else begin
      acc   <= acc_nxt;
      fill  <= fill_nxt;
      tmo   <= tmo_nxt;
    end
  end
endmodule

// File: rtl/mure_regrouper.sv
// Re-packs the one-instruction-per-beat trace stream into commit-port shaped retirement groups.
module mure_regrouper import mure_pkg::*; #(
  parameter int unsigned RETIRED_INSTR = SLOTS,
  parameter int unsigned TIMEOUT       = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              inst_valid_i,
  input  logic                              iretired_i,
  input  logic                              exception_i,
  input  logic                              interrupt_i,
  input  logic [INST_LEN-1:0]               inst_data_i,
  input  logic [XLEN-1:0]                   pc_i,
  input  logic [XLEN-1:0]                   epc_i,
  output logic                              ready_o,
  output logic                              group_valid_o,
  input  logic                              group_ready_i,
  output logic [RETIRED_INSTR-1:0]          valids_o,
  output logic [RETIRED_INSTR*INST_LEN-1:0] uops_o,
  output logic [RETIRED_INSTR*XLEN-1:0]     pcs_o,
  output logic                              exception_o,
  output logic                              interrupt_o,
  output logic [XLEN-1:0]                   epc_o
);
  regroup_t acc_group, out;
  logic     acc_avail, take, out_valid;

  mure_regroup_acc #(.TIMEOUT(TIMEOUT)) u_acc (
    .clk        (clk_i),
    .rst        (rst_i),
    .inst_valid (inst_valid_i),
    .iretired   (iretired_i),
    .exception  (exception_i),
    .interrupt  (interrupt_i),
    .inst_data  (inst_data_i),
    .pc         (pc_i),
    .epc        (epc_i),
    .take       (take),
    .ready      (ready_o),
    .avail      (acc_avail),
    .group      (acc_group)
  );

  assign take = acc_avail && (!out_valid || group_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out       <= acc_group;
    end else if (group_ready_i) begin
      out_valid <= 1'b0;
      out       <= '0;
    end
  end

  assign group_valid_o = out_valid;
  assign valids_o      = out.valids;
  assign uops_o        = out.uops;
  assign pcs_o         = out.pcs;
  assign exception_o   = out.exception;
  assign interrupt_o   = out.interrupt;
  assign epc_o         = out.epc;
endmodule

// File: tb/tb_mure_regrouper.sv
// Scoreboard bench for mure_regrouper with RETIRED_INSTR=2, TIMEOUT=8.
module tb_mure_regrouper;
  localparam int unsigned TMO = 8;
  localparam int unsigned GW  = 2 + 64 + 64 + 1 + 1 + 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, iretired, exception, interrupt;
  logic [31:0] inst_data, pc, epc;
  logic        ready, group_valid, group_ready;
  logic [1:0]  valids;
  logic [63:0] uops, pcs;
  logic        exception_out, interrupt_out;
  logic [31:0] epc_out;

  int vectors    = 0;
  int miscompares = 0;
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] exp_head;
  logic [GW-1:0] actual;

  always #5 clk = ~clk;

  mure_regrouper #(.RETIRED_INSTR(2), .TIMEOUT(TMO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .inst_valid_i  (inst_valid),
    .iretired_i    (iretired),
    .exception_i   (exception),
    .interrupt_i   (interrupt),
    .inst_data_i   (inst_data),
    .pc_i          (pc),
    .epc_i         (epc),
    .ready_o       (ready),
    .group_valid_o (group_valid),
    .group_ready_i (group_ready),
    .valids_o      (valids),
    .uops_o        (uops),
    .pcs_o         (pcs),
    .exception_o   (exception_out),
    .interrupt_o   (interrupt_out),
    .epc_o         (epc_out)
  );

  assign actual = {valids, uops, pcs, exception_out, interrupt_out, epc_out};

  function automatic logic [GW-1:0] mk(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                                       input logic exc, input logic intr, input logic [31:0] e);
    logic [31:0] u0, u1, p0, p1;
    u0 = v[0] ? {16'hC0DE, pc0[15:0]} : 32'h0;
    u1 = v[1] ? {16'hC0DE, pc1[15:0]} : 32'h0;
    p0 = v[0] ? pc0 : 32'h0;
    p1 = v[1] ? pc1 : 32'h0;
    return {v, u1, u0, p1, p0, exc, intr, e};
  endfunction

  // Output monitor: every handshake pops the oldest expected group.
  always @(negedge clk) begin
    if (!rst && group_valid && group_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL group_unexpected got=%h", actual);
      end else begin
        exp_head = exp_q.pop_front();
        if (actual !== exp_head) begin
          miscompares++;
          $display("FAIL group_content got=%h want=%h", actual, exp_head);
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid = 1'b0; iretired = 1'b0; exception = 1'b0; interrupt = 1'b0;
  endtask

  // Holds the beat on the inputs until an edge accepts it; leaves it driven for back-to-back use.
  task automatic send_beat(input logic ret, input logic exc, input logic intr,
                           input logic [31:0] p, input logic [31:0] e);
    int unsigned n;
    logic took;
    inst_valid = 1'b1; iretired = ret; exception = exc; interrupt = intr;
    pc = p; inst_data = {16'hC0DE, p[15:0]}; epc = e;
    took = 1'b0; n = 0;
    while (!took && n < 50) begin
      @(negedge clk);
      took = ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout pc=%h got=not_accepted want=accepted", p);
    end
  endtask

  task automatic wait_drained(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick(1);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain got=%0d_pending want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; group_ready = 1'b1; idle();
    pc = '0; epc = '0; inst_data = '0;
    tick(3);
    vectors++;
    if ({group_valid, actual} !== '0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state got=%b/%h ready=%b want=0/0 ready=1", group_valid, actual, ready);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_pair();
    exp_q.push_back(mk(2'b11, 32'h1000, 32'h1004, 1'b0, 1'b0, 32'h0));
    send_beat(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0);
    send_beat(1'b1, 1'b0, 1'b0, 32'h1004, 32'h0);
    idle();
    vectors++;
    if (group_valid !== 1'b1 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pair_latency got=valid%b ready%b want=valid1 ready1", group_valid, ready);
    end
    wait_drained("pair");
  endtask

  task automatic test_timeout();
    int unsigned n;
    exp_q.push_back(mk(2'b01, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0));
    send_beat(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0);
    idle();
    n = 0;
    while (!group_valid && n < 30) begin
      tick(1);
      n++;
    end
    vectors++;
    if (n < TMO || n > TMO + 1) begin
      miscompares++;
      $display("FAIL timeout_delay got=%0d want=%0d..%0d", n, TMO, TMO + 1);
    end
    wait_drained("timeout");
  endtask

  task automatic test_trap_close();
    exp_q.push_back(mk(2'b01, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h2000));
    send_beat(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0);
    send_beat(1'b0, 1'b1, 1'b0, 32'h1008, 32'h2000);
    idle();
    wait_drained("trap");
  endtask

  task automatic test_full_and_trap();
    exp_q.push_back(mk(2'b11, 32'h6000, 32'h6004, 1'b1, 1'b0, 32'h6100));
    send_beat(1'b1, 1'b0, 1'b0, 32'h6000, 32'h0);
    send_beat(1'b1, 1'b1, 1'b0, 32'h6004, 32'h6100);
    idle();
    wait_drained("full_trap");
  endtask

  task automatic test_dropped_beat();
    exp_q.push_back(mk(2'b11, 32'h5000, 32'h5004, 1'b0, 1'b0, 32'h0));
    send_beat(1'b1, 1'b0, 1'b0, 32'h5000, 32'h0);
    send_beat(1'b0, 1'b0, 1'b0, 32'h5ff0, 32'h0);
    send_beat(1'b1, 1'b0, 1'b0, 32'h5004, 32'h0);
    idle();
    wait_drained("dropped");
  endtask

  task automatic test_back_to_back();
    logic [GW-1:0] held;
    held = mk(2'b11, 32'h7000, 32'h7004, 1'b0, 1'b0, 32'h0);
    group_ready = 1'b0;
    exp_q.push_back(held);
    exp_q.push_back(mk(2'b11, 32'h7008, 32'h700c, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mk(2'b11, 32'h7010, 32'h7014, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 4; i++) send_beat(1'b1, 1'b0, 1'b0, 32'h7000 + 32'(4 * i), 32'h0);
    inst_valid = 1'b1; pc = 32'h7010; inst_data = {16'hC0DE, 16'h7010};
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (ready !== 1'b0 || group_valid !== 1'b1 || actual !== held) begin
        miscompares++;
        $display("FAIL bp_hold got=ready%b valid%b %h want=ready0 valid1 %h", ready, group_valid, actual, held);
      end
      tick(1);
    end
    group_ready = 1'b1;
    send_beat(1'b1, 1'b0, 1'b0, 32'h7010, 32'h0);
    send_beat(1'b1, 1'b0, 1'b0, 32'h7014, 32'h0);
    idle();
    wait_drained("back_to_back");
  endtask

  task automatic test_reset_midfill();
    group_ready = 1'b0;
    exp_q.push_back(mk(2'b11, 32'h8000, 32'h8004, 1'b0, 1'b0, 32'h0));
    send_beat(1'b1, 1'b0, 1'b0, 32'h8000, 32'h0);
    send_beat(1'b1, 1'b0, 1'b0, 32'h8004, 32'h0);
    send_beat(1'b1, 1'b0, 1'b0, 32'h8008, 32'h0);
    idle();
    rst = 1'b1;
    tick(1);
    vectors++;
    if ({group_valid, actual} !== '0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midfill_reset got=%b/%h ready=%b want=0/0 ready=1", group_valid, actual, ready);
    end
    exp_q.delete();
    rst = 1'b0;
    group_ready = 1'b1;
    exp_q.push_back(mk(2'b11, 32'h3000, 32'h3004, 1'b0, 1'b0, 32'h0));
    send_beat(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0);
    send_beat(1'b1, 1'b0, 1'b0, 32'h3004, 32'h0);
    idle();
    wait_drained("post_reset");
  endtask

  task automatic test_empty_interrupt();
    exp_q.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4000));
    send_beat(1'b0, 1'b1, 1'b1, 32'h4010, 32'h4000);
    idle();
    wait_drained("empty_irq");
  endtask

  initial begin
    test_reset();
    test_pair();
    test_timeout();
    test_trap_close();
    test_full_and_trap();
    test_dropped_beat();
    test_back_to_back();
    test_reset_midfill();
    test_empty_interrupt();
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
